// File: rtl/reg_watch_monitor.sv
// reg_watch_monitor: snoops the register-file write port, shadows a window
// of NUM_CH registers, counts run cycles and detects done/pass or timeout.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_en/addr/data      snooped register-file write port
//   run_en               arm (IDLE->RUN) and count enable while running
//   clear                synchronous clear of all state
//   watch_data           shadow values, channel i at [i*DATA_W +: DATA_W]
//   watch_upd            one-cycle pulse per channel on shadow update
//   cycle_cnt            run cycle count (saturating, frozen at end)
//   state                0=IDLE 1=RUN 2=DONE 3=TMO
//   done, pass, timeout  sticky status flags
//
// Optional: define REG_WATCH_DISPLAY_EN for simulation-only $display
// tracing of shadow updates and test completion.

module reg_watch_monitor #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_CH     = 3,
    parameter int WATCH_BASE = 27,
    parameter int DONE_REG   = 26,
    parameter int PASS_REG   = 27,
    parameter int TIMEOUT    = 100000,
    parameter int CNT_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     run_en,
    input  logic                     clear,
    output logic [NUM_CH*DATA_W-1:0] watch_data,
    output logic [NUM_CH-1:0]        watch_upd,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [1:0]               state,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout
);

    generate
        if (WATCH_BASE + NUM_CH > 2 ** ADDR_W) begin : g_bad_window
            $fatal(1, "reg_watch_monitor: watch window exceeds address space");
        end
        if (TIMEOUT < 2) begin : g_bad_timeout
            $fatal(1, "reg_watch_monitor: TIMEOUT must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        TMO  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] DONE_ADDR = ADDR_W'(DONE_REG);
    localparam logic [ADDR_W-1:0] PASS_ADDR = ADDR_W'(PASS_REG);
    localparam logic [CNT_W-1:0]  TMO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);

    state_t                   state_q, state_d;
    logic [NUM_CH*DATA_W-1:0] sh_q, sh_d;
    logic [NUM_CH-1:0]        upd_q, upd_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     done_q, done_d;
    logic                     pass_q, pass_d;
    logic                     tmo_q, tmo_d;
    logic                     psh_q, psh_d;

    logic              wr_ok;
    logic [NUM_CH-1:0] hit;
    logic              done_hit;
    logic              inc;

    // x0 is hardwired zero in the core, so its writes never count
    assign wr_ok    = wr_en && (wr_addr != '0);
    assign done_hit = wr_ok && (wr_addr == DONE_ADDR) && (wr_data == ONE);
    assign inc      = run_en && (cnt_q != '1);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hit[i] = wr_ok && (wr_addr == ADDR_W'(WATCH_BASE + i));
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        upd_d   = '0;
        cnt_d   = cnt_q;
        done_d  = done_q;
        pass_d  = pass_q;
        tmo_d   = tmo_q;
        psh_d   = psh_q;

        for (int i = 0; i < NUM_CH; i++) begin
            if (hit[i]) begin
                sh_d[i*DATA_W +: DATA_W] = wr_data;
                upd_d[i]                 = 1'b1;
            end
        end

        // only "value == 1" matters at done time, so one bit suffices
        if (wr_ok && (wr_addr == PASS_ADDR)) begin
            psh_d = (wr_data == ONE);
        end

        unique case (state_q)
            IDLE: begin
                if (run_en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (inc) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // done is checked first so it wins a same-cycle timeout
                if (done_hit) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = psh_q;
                end else if (inc && (cnt_q == TMO_LAST)) begin
                    state_d = TMO;
                    tmo_d   = 1'b1;
                end
            end
            DONE: begin
            end
            TMO: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clear) begin
            state_d = IDLE;
            sh_d    = '0;
            upd_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            pass_d  = 1'b0;
            tmo_d   = 1'b0;
            psh_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sh_q    <= '0;
            upd_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            tmo_q   <= 1'b0;
            psh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            upd_q   <= upd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            tmo_q   <= tmo_d;
            psh_q   <= psh_d;
        end
    end

    assign watch_data = sh_q;
    assign watch_upd  = upd_q;
    assign cycle_cnt  = cnt_q;
    assign state      = state_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign timeout    = tmo_q;

`ifdef REG_WATCH_DISPLAY_EN
    logic done_seen, tmo_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_seen <= 1'b0;
            tmo_seen  <= 1'b0;
        end else begin
            done_seen <= done_q;
            tmo_seen  <= tmo_q;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (upd_q[i]) begin
                    $display("reg_watch: x%0d = %0d at cycle %0d",
                             WATCH_BASE + i,
                             sh_q[i*DATA_W +: DATA_W], cnt_q);
                end
            end
            if (done_q && !done_seen) begin
                $display("reg_watch: test %s at cycle %0d",
                         pass_q ? "PASS" : "FAIL", cnt_q);
            end
            if (tmo_q && !tmo_seen) begin
                $display("reg_watch: timeout at cycle %0d", cnt_q);
            end
        end
    end
`endif

endmodule

// File: tb/tb_reg_watch_monitor.sv
// tb_reg_watch_monitor: directed self-checking bench for reg_watch_monitor
// with a shadow/pulse scoreboard and TIMEOUT shortened to 20.

module tb_reg_watch_monitor;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NCH = 3;
    localparam int WB  = 27;
    localparam int TO  = 20;
    localparam int CW  = 32;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              run_en;
    logic              clear;
    logic [NCH*DW-1:0] watch_data;
    logic [NCH-1:0]    watch_upd;
    logic [CW-1:0]     cycle_cnt;
    logic [1:0]        state;
    logic              done;
    logic              pass;
    logic              timeout;

    reg_watch_monitor #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NCH), .WATCH_BASE(WB),
        .DONE_REG(26), .PASS_REG(27), .TIMEOUT(TO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .run_en(run_en), .clear(clear),
        .watch_data(watch_data), .watch_upd(watch_upd),
        .cycle_cnt(cycle_cnt), .state(state),
        .done(done), .pass(pass), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCH-1:0]    upd;
        logic [NCH*DW-1:0] data;
    } exp_t;

    exp_t              sbq[$];
    logic [NCH*DW-1:0] msh;
    int                total;
    int                bad;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // predict shadow/pulse from driven inputs, clock, then score
    task automatic cyc();
        exp_t e;
        int   a;
        e.upd = '0;
        a     = int'(wr_addr);
        if (clear) begin
            msh = '0;
        end else if (wr_en && a != 0 && a >= WB && a < WB + NCH) begin
            msh[(a-WB)*DW +: DW] = wr_data;
            e.upd[a-WB]          = 1'b1;
        end
        e.data = msh;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = sbq.pop_front();
            chk("watch_upd", 128'(watch_upd), 128'(e.upd));
            chk("watch_data", 128'(watch_data), 128'(e.data));
        end
    endtask

    task automatic idle_in();
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        clear   = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = DW'(d);
        cyc();
        idle_in();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic chk_status(input string tag, input int st, input int c,
                              input logic d, input logic p, input logic t);
        chk({tag, "_state"}, 128'(state), 128'(st));
        chk({tag, "_cnt"}, 128'(cycle_cnt), 128'(c));
        chk({tag, "_flags"}, 128'({done, pass, timeout}),
            128'({d, p, t}));
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        msh    = '0;
        rst    = 1'b1;
        run_en = 1'b0;
        idle_in();

        // reset and arm
        repeat (3) @(posedge clk);
        #1;
        chk_status("rst", 0, 0, 0, 0, 0);
        chk("rst_watch", 128'({watch_data, watch_upd}), 0);
        rst    = 1'b0;
        run_en = 1'b1;
        chk("arm_idle", 128'(state), 0);
        cyc();
        chk_status("arm_run", 1, 0, 0, 0, 0);
        repeat (10) cyc();
        chk_status("run10", 1, 10, 0, 0, 0);

        // shadow update, single pulse, x0 ignored
        wr(28, 5);
        chk("ch1_5", 128'(watch_data[DW +: DW]), 5);
        chk("upd_010", 128'(watch_upd), 128'(3'b010));
        cyc();
        wr(0, 7);
        chk_status("x0", 1, 13, 0, 0, 0);

        // pass run
        wr(27, 1);
        wr(26, 1);
        chk_status("pass", 2, 15, 1, 1, 0);
        repeat (3) cyc();
        chk_status("pass_frz", 2, 15, 1, 1, 0);
        wr(29, 9);
        chk("done_track", 128'(watch_data[2*DW +: DW]), 9);

        // clear from DONE
        do_clear();
        chk_status("clr", 0, 0, 0, 0, 0);
        chk("clr_watch", 128'({watch_data, watch_upd}), 0);

        // fail run with pause
        cyc();
        chk("rearm", 128'(state), 1);
        repeat (4) cyc();
        run_en = 1'b0;
        repeat (5) cyc();
        chk_status("pause", 1, 4, 0, 0, 0);
        run_en = 1'b1;
        wr(27, 0);
        wr(26, 1);
        chk_status("fail", 2, 6, 1, 0, 0);
        wr(26, 2);
        chk_status("fail_hold", 2, 6, 1, 0, 0);

        // timeout
        do_clear();
        cyc();
        repeat (19) cyc();
        chk_status("pre_tmo", 1, 19, 0, 0, 0);
        cyc();
        chk_status("tmo", 3, 20, 0, 0, 1);
        repeat (2) cyc();
        chk_status("tmo_frz", 3, 20, 0, 0, 1);

        // done write on the last count cycle beats timeout
        do_clear();
        cyc();
        repeat (19) cyc();
        wr(26, 1);
        chk_status("done_wins", 2, 20, 1, 0, 0);

        // async reset between edges
        do_clear();
        cyc();
        wr(29, 3);
        repeat (3) cyc();
        #2;
        rst = 1'b1;
        #1;
        chk_status("arst", 0, 0, 0, 0, 0);
        chk("arst_watch", 128'({watch_data, watch_upd}), 0);
        sbq.delete();
        msh = '0;
        #10;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_arst", 128'(state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

endmodule
